// File: rtl/noc_endpoint_tx_if.sv
// Client stream plus router local-port signals for the NoC injection endpoint.
// master = client/router side, slave = noc_endpoint_tx.
interface noc_endpoint_tx_if #(
  parameter int DEST_WIDTH = 4,
  parameter int FLIT_WIDTH = 256
);
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;

  modport master (
    output in_data, in_dest, in_last, in_valid, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport slave (
    input  in_data, in_dest, in_last, in_valid, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_endpoint_tx.sv
// Credit-based NoC injection endpoint: accepts client flits, latches the head destination,
// and never sends into a full router buffer. Optional counters under NOC_TX_STATS_EN.
module noc_endpoint_tx #(
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  noc_endpoint_tx_if.slave     bus,
  output logic                 credit_err
`ifdef NOC_TX_STATS_EN
  ,
  output logic [31:0]          flit_count,
  output logic [31:0]          pkt_count
`endif
);

  localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef enum logic {HEAD, BODY} state_t;

  state_t                  state_reg, state_next;
  logic [CREDIT_WIDTH-1:0] credits_reg;
  logic [DEST_WIDTH-1:0]   dest_reg;
  logic [DEST_WIDTH-1:0]   dest_sel;
  logic [FLIT_WIDTH-1:0]   data_reg;
  logic [DEST_WIDTH-1:0]   dest_out_reg;
  logic                    tail_reg;
  logic                    send_reg;
  logic                    err_reg;
  logic                    ready;
  logic                    accept;

  assign accept = bus.in_valid && ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= HEAD;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      case (state_reg)
        HEAD:    state_next = bus.in_last ? HEAD : BODY;
        BODY:    state_next = bus.in_last ? HEAD : BODY;
        default: state_next = HEAD;
      endcase
    end
  end

  // FSM: outputs; ready depends only on registered credits (and reset)
  always_comb begin
    ready    = rst_n && (credits_reg != '0);
    dest_sel = (state_reg == HEAD) ? bus.in_dest : dest_reg;
  end

  assign bus.in_ready    = ready;
  assign bus.data_out    = data_reg;
  assign bus.dest_out    = dest_out_reg;
  assign bus.is_tail_out = tail_reg;
  assign bus.send_out    = send_reg;
  assign credit_err      = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_reg     <= 1'b0;
      data_reg     <= '0;
      dest_out_reg <= '0;
      tail_reg     <= 1'b0;
      dest_reg     <= '0;
    end else begin
      send_reg <= accept;
      if (accept) begin
        data_reg     <= bus.in_data;
        dest_out_reg <= dest_sel;
        tail_reg     <= bus.in_last;
        if (state_reg == HEAD) dest_reg <= bus.in_dest;
      end
    end
  end

  // A simultaneous accept and credit return cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_reg <= CREDIT_MAX;
      err_reg     <= 1'b0;
    end else if (accept && !bus.credit_in) begin
      credits_reg <= credits_reg - 1'b1;
    end else if (!accept && bus.credit_in) begin
      if (credits_reg == CREDIT_MAX) err_reg <= 1'b1;
      else                           credits_reg <= credits_reg + 1'b1;
    end
  end

`ifdef NOC_TX_STATS_EN
  // Counted at accept so the counts line up with the send_out pulse they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_count <= '0;
      pkt_count  <= '0;
    end else if (accept) begin
      flit_count <= flit_count + 32'd1;
      if (bus.in_last) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/noc_endpoint_tx.md
Name: noc_endpoint_tx

Overview:
Injection-side endpoint adapter that drives one NoC router local input port (data/dest/is_tail/send with credit return). It takes flits from a client over a valid/ready stream and tracks downstream buffer credits so that no flit is ever sent into a full router buffer. It latches the packet destination on the head flit and holds it for the whole packet. One instance sits on each endpoint's injection port of the ring.

Parameters:
DEST_WIDTH, 4, width of endpoint destination ID
FLIT_WIDTH, 256, flit payload width
FLIT_BUFFER_DEPTH, 2, router input buffer depth; initial and maximum credit count
CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived; do not override)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_data  input  FLIT_WIDTH  client flit payload
in_dest  input  DEST_WIDTH  destination; sampled on head flit only
in_last  input  1  marks final flit of packet
in_valid  input  1  client flit valid
in_ready  output  1  block accepts flit this cycle
data_out  output  FLIT_WIDTH  flit to router
dest_out  output  DEST_WIDTH  destination to router
is_tail_out  output  1  tail marker to router
send_out  output  1  one-cycle pulse per flit sent
credit_in  input  1  one-cycle pulse per router buffer slot freed
credit_err  output  1  sticky credit overflow flag
flit_count  output  32  flits sent (present only with NOC_TX_STATS_EN)
pkt_count  output  32  tail flits sent (present only with NOC_TX_STATS_EN)

Behaviour:
- Reset (async, rst_n=0): credits=FLIT_BUFFER_DEPTH, FSM=HEAD, send_out=0, is_tail_out=0, data_out=0, dest_out=0, credit_err=0, counters=0. in_ready is forced to 0 while rst_n=0.
- in_ready = (credits != 0); it is combinational from registered state only and does not depend on in_valid or credit_in.
- Accept = in_valid && in_ready.
- On accept, the next cycle gives send_out=1, data_out=in_data, is_tail_out=in_last, and dest_out per the FSM. Latency is exactly 1 cycle. Without an accept, send_out=0 next cycle; data/dest/tail hold their last value.
- Throughput: 1 flit/cycle while credits are available.
- Credit update:
  - accept only: credits-1
  - credit_in only: credits+1
  - both in the same cycle: unchanged
- Overflow: credit_in with credits==FLIT_BUFFER_DEPTH and no accept sets credit_err (sticky until reset). credits stays saturated at FLIT_BUFFER_DEPTH.
- FSM, HEAD state: on accept, dest_reg<=in_dest and dest_out<=in_dest. If in_last=1, stay in HEAD (single-flit packet); otherwise go to BODY.
- FSM, BODY state: on accept, dest_out<=dest_reg and in_dest is ignored. in_last=1 goes to HEAD; otherwise stay in BODY.
- Credits exhausted mid-packet: FSM stays in BODY and in_ready=0 until credit_in arrives. No flits are dropped.
- Reset mid-packet: FSM returns to HEAD and credits are restored to full. The partial packet is abandoned; upstream and router reset together.

Optional Feature:
NOC_TX_STATS_EN
- Defined: flit_count increments on every send_out pulse. pkt_count increments on every send_out with is_tail_out=1. Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, DEPTH=2, credit_in=0, in_valid=1 continuous -> exactly 2 send_out pulses on cycles 1,2 after first accept, then in_ready=0 indefinitely.
- Same as above, then one credit_in pulse -> in_ready=1 next cycle, exactly one more flit sent, in_ready=0 again.
- 3-flit packet, dest 5 on head, in_dest=9 on body flits -> dest_out=5 on all 3 flits, is_tail_out=1 only on flit 3, FSM ends in HEAD.
- Back-to-back single-flit packets dest 1,2,3 with ample credits -> three consecutive send_out cycles with dest_out 1,2,3 and is_tail_out=1 on each.
- credits=1, accept and credit_in in the same cycle -> credits remains 1, in_ready stays 1; credit_in at full credits -> credit_err=1 and stays 1.
- Assert rst_n=0 mid-packet (after head, before tail) -> send_out=0 immediately; after release credits=DEPTH, next accepted flit's in_dest is latched as head; with NOC_TX_STATS_EN, 4 packets of 2 flits -> flit_count=8, pkt_count=4.
